// File: rtl/object_catcher_if.sv
// Bus between the falling-object catcher and its surroundings: game controls and
// object/player coordinates in, object position, pulses and scoreboard out.
interface object_catcher_if #(
    parameter int SCORE_W = 16
);
    logic               start;
    logic               frame_tick;
    logic [10:0]        object_position;
    logic [10:0]        player_position;
    logic [10:0]        object_x;
    logic [10:0]        object_y;
    logic               spawn_req;
    logic               catch_pulse;
    logic               miss_pulse;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;
    logic               game_over;

    modport master (
        output start, frame_tick, object_position, player_position,
        input  object_x, object_y, spawn_req, catch_pulse, miss_pulse,
               score, lives, game_over
    );

    modport slave (
        input  start, frame_tick, object_position, player_position,
        output object_x, object_y, spawn_req, catch_pulse, miss_pulse,
               score, lives, game_over
    );
endinterface

// File: rtl/object_catcher.sv
// Falling-object game core: latches a spawn position, drops the object once per
// frame, judges catch/miss at the catch line and keeps score, lives and game over.
module object_catcher #(
    parameter int PLAYER_Y   = 440,
    parameter int FALL_STEP  = 8,
    parameter int OBJ_W      = 32,
    parameter int PLAYER_W   = 64,
    parameter int LIVES_INIT = 3,
    parameter int SCORE_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    object_catcher_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        RESPAWN,
        FALL,
        CHECK,
        OVER
    } state_t;

    localparam logic [11:0]        PLAYER_Y_W   = 12'(PLAYER_Y);
    localparam logic [10:0]        PLAYER_Y_ROW = 11'(PLAYER_Y);
    localparam logic [11:0]        FALL_STEP_W  = 12'(FALL_STEP);
    localparam logic [11:0]        OBJ_W_W      = 12'(OBJ_W);
    localparam logic [11:0]        PLAYER_W_W   = 12'(PLAYER_W);
    localparam logic [2:0]         LIVES_RESET  = 3'(LIVES_INIT);
    localparam logic [SCORE_W-1:0] SCORE_ONE    = {{(SCORE_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [10:0]        object_x_q, object_x_d;
    logic [10:0]        object_y_q, object_y_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               spawn_req_q, spawn_req_d;
    logic               catch_pulse_q, catch_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic               game_over_q, game_over_d;

    logic [11:0] y_sum;
    logic [11:0] obj_right;
    logic [11:0] player_right;
    logic        overlap;

    // All geometry is widened to 12 bits so objects near the right screen edge cannot wrap.
    always_comb begin
        y_sum        = {1'b0, object_y_q} + FALL_STEP_W;
        obj_right    = {1'b0, object_x_q} + OBJ_W_W;
        player_right = {1'b0, bus.player_position} + PLAYER_W_W;
        overlap      = (obj_right > {1'b0, bus.player_position}) &&
                       ({1'b0, object_x_q} < player_right);
    end

    always_comb begin
        state_d       = state_q;
        object_x_d    = object_x_q;
        object_y_d    = object_y_q;
        score_d       = score_q;
        lives_d       = lives_q;
        spawn_req_d   = 1'b0;
        catch_pulse_d = 1'b0;
        miss_pulse_d  = 1'b0;
        game_over_d   = game_over_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RESPAWN;
                    spawn_req_d = 1'b1;
                end
            end
            RESPAWN: begin
                object_x_d = bus.object_position;
                object_y_d = '0;
                state_d    = FALL;
            end
            FALL: begin
                // The catch verdict is registered on the landing tick so the pulse lines up with CHECK.
                if (bus.frame_tick) begin
                    if (y_sum >= PLAYER_Y_W) begin
                        object_y_d = PLAYER_Y_ROW;
                        state_d    = CHECK;
                        if (overlap) begin
                            catch_pulse_d = 1'b1;
                            score_d       = (score_q == '1) ? score_q : score_q + SCORE_ONE;
                        end else begin
                            miss_pulse_d = 1'b1;
                            lives_d      = lives_q - 3'd1;
                        end
                    end else begin
                        object_y_d = y_sum[10:0];
                    end
                end
            end
            CHECK: begin
                if (miss_pulse_q && (lives_q == 3'd0)) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d     = RESPAWN;
                    spawn_req_d = 1'b1;
                end
            end
            OVER: begin
                if (bus.start) begin
                    score_d     = '0;
                    lives_d     = LIVES_RESET;
                    game_over_d = 1'b0;
                    state_d     = RESPAWN;
                    spawn_req_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            object_x_q    <= '0;
            object_y_q    <= '0;
            score_q       <= '0;
            lives_q       <= LIVES_RESET;
            spawn_req_q   <= 1'b0;
            catch_pulse_q <= 1'b0;
            miss_pulse_q  <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            object_x_q    <= object_x_d;
            object_y_q    <= object_y_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            spawn_req_q   <= spawn_req_d;
            catch_pulse_q <= catch_pulse_d;
            miss_pulse_q  <= miss_pulse_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.object_x    = object_x_q;
    assign bus.object_y    = object_y_q;
    assign bus.score       = score_q;
    assign bus.lives       = lives_q;
    assign bus.spawn_req   = spawn_req_q;
    assign bus.catch_pulse = catch_pulse_q;
    assign bus.miss_pulse  = miss_pulse_q;
    assign bus.game_over   = game_over_q;

endmodule
